// File: rtl/fetch_stage.sv
// RV32I instruction fetch: owns the PC, talks to the I-cache and
// drives the IF/ID register with stall, redirect and stale-response drop.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0060,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_read,
  output logic [31:0] inst_addr,
  input  logic        inst_resp,
  input  logic [31:0] inst_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr
);

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } hold_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] req_q;
  logic [31:0] req_d;
  hold_t       hold_q;
  hold_t       hold_d;
  if_id_t      id_q;
  if_id_t      id_d;

  logic [31:0] pc_inc;
  logic [31:0] tgt_pc;
  if_id_t      id_empty;

  logic ev_redir;
  logic ev_take;
  logic ev_park;
  logic ev_idle;

  assign pc_inc   = pc_q + 32'd4;
  assign tgt_pc   = {redirect_pc[31:2], 2'b00};
  assign id_empty = '{valid: 1'b0, pc: id_q.pc, instr: NOP_INSTR};

  // One-hot view of what can happen while a request is outstanding
  assign ev_redir = redirect_valid;
  assign ev_take  = !redirect_valid && inst_resp && !stall;
  assign ev_park  = !redirect_valid && inst_resp && stall;
  assign ev_idle  = !redirect_valid && !inst_resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REQ;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      REQ: begin
        if (redirect_valid) begin
          state_d = inst_resp ? REQ : DISCARD;
        end else if (inst_resp && stall) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid || !stall) begin
          state_d = REQ;
        end
      end
      DISCARD: begin
        if (inst_resp) begin
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  always_comb begin
    inst_read = !rst && (state_q != HOLD);
    inst_addr = req_q;
    id_valid  = id_q.valid;
    id_pc     = id_q.pc;
    id_instr  = id_q.instr;
  end

  always_comb begin
    pc_d   = pc_q;
    req_d  = req_q;
    hold_d = hold_q;
    id_d   = id_q;
    unique case (state_q)
      REQ: begin
        unique case (1'b1)
          ev_redir: begin
            id_d = id_empty;
            pc_d = tgt_pc;
            if (inst_resp) begin
              req_d = tgt_pc;
            end
          end
          ev_take: begin
            id_d  = '{valid: 1'b1, pc: req_q, instr: inst_rdata};
            pc_d  = pc_inc;
            req_d = pc_inc;
          end
          ev_park: begin
            hold_d = '{pc: req_q, instr: inst_rdata};
          end
          ev_idle: begin
            if (!stall) begin
              id_d = id_empty;
            end
          end
          default: id_d = id_q;
        endcase
      end
      HOLD: begin
        if (redirect_valid) begin
          id_d  = id_empty;
          pc_d  = tgt_pc;
          req_d = tgt_pc;
        end else if (!stall) begin
          id_d  = '{valid: 1'b1, pc: hold_q.pc, instr: hold_q.instr};
          pc_d  = pc_inc;
          req_d = pc_inc;
        end
      end
      DISCARD: begin
        id_d = id_empty;
        if (redirect_valid) begin
          pc_d = tgt_pc;
        end
        // Stale response closes the old request; reissue at the latest target
        if (inst_resp) begin
          req_d = redirect_valid ? tgt_pc : pc_q;
        end
      end
      default: begin
        id_d = id_empty;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      req_q  <= RESET_PC;
      hold_q <= '0;
      id_q   <= '{valid: 1'b0, pc: 32'h0, instr: NOP_INSTR};
    end else begin
      pc_q   <= pc_d;
      req_q  <= req_d;
      hold_q <= hold_d;
      id_q   <= id_d;
    end
  end

endmodule
